lfsr_period_checker: RTL and testbench

LFSR_PERIOD_CHECKER -- requirements
Module: lfsr_period_checker

---
 rtl/lfsr_period_checker.sv | 175 +++++++++++++++++
 tb/tb_lfsr_period_checker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_period_checker.sv
// lfsr_period_checker: measures the repeat period of an upstream LFSR state stream.
// A start request arms a capture of the next valid state word as the reference.
// Subsequent valid samples are counted until the reference reappears (done),
// until an all-zero lockup state is seen (lockup), or until the counter range
// is exhausted (timeout). Cycles with in_valid=0 leave everything untouched.
module lfsr_period_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] state_in,
    output logic [WIDTH-1:0] ref_state,
    output logic [CNT_W-1:0] period,
    output logic             busy,
    output logic             done,
    output logic             lockup,
    output logic             timeout
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        COUNT,
        DONE,
        FAULT
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] count_inc;

    logic [WIDTH-1:0] ref_d;
    logic [CNT_W-1:0] period_d;
    logic             busy_d;
    logic             done_d;
    logic             lockup_d;
    logic             timeout_d;

    logic start_ok;
    logic is_zero;
    logic is_match;
    logic at_limit;

    // Sample decode shared by the next-state and output logic
    assign count_inc = count_q + CNT_W'(1);
    assign is_zero   = (state_in == '0);
    assign is_match  = (state_in == ref_state);
    assign at_limit  = (count_inc == '1);
    assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == FAULT));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; match outranks zero, zero outranks timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, FAULT: begin
                if (start_ok) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    state_d = is_zero ? FAULT : COUNT;
                end
            end
            COUNT: begin
                if (in_valid) begin
                    if (is_match) begin
                        state_d = DONE;
                    end else if (is_zero || at_limit) begin
                        state_d = FAULT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and the period counter
    always_comb begin
        ref_d     = ref_state;
        period_d  = period;
        busy_d    = busy;
        done_d    = done;
        lockup_d  = lockup;
        timeout_d = timeout;
        count_d   = count_q;
        case (state_q)
            IDLE, DONE, FAULT: begin
                if (start_ok) begin
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    lockup_d  = 1'b0;
                    timeout_d = 1'b0;
                    period_d  = '0;
                    count_d   = '0;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    ref_d   = state_in;
                    count_d = '0;
                    if (is_zero) begin
                        lockup_d = 1'b1;
                        busy_d   = 1'b0;
                        period_d = '0;
                    end
                end
            end
            COUNT: begin
                if (in_valid) begin
                    count_d = count_inc;
                    if (is_match) begin
                        // a match on the saturating sample still reports the full range
                        period_d = count_inc;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                    end else if (is_zero) begin
                        lockup_d = 1'b1;
                        busy_d   = 1'b0;
                        period_d = '0;
                    end else if (at_limit) begin
                        timeout_d = 1'b1;
                        busy_d    = 1'b0;
                    end
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_state <= '0;
            period    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            lockup    <= 1'b0;
            timeout   <= 1'b0;
            count_q   <= '0;
        end else begin
            ref_state <= ref_d;
            period    <= period_d;
            busy      <= busy_d;
            done      <= done_d;
            lockup    <= lockup_d;
            timeout   <= timeout_d;
            count_q   <= count_d;
        end
    end

    a_flags_exclusive : assert property (@(posedge clk) disable iff (!rst)
        $onehot0({done, lockup, timeout}));

    a_busy_no_flags : assert property (@(posedge clk) disable iff (!rst)
        busy |-> !(done || lockup || timeout));

endmodule

// File: tb/tb_lfsr_period_checker.sv
// Testbench for lfsr_period_checker: scoreboard of expected result events
// pushed when a measurement is launched and popped when a result flag rises.
module tb_lfsr_period_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] state_in = '0;
    logic [3:0] ref_state;
    logic [7:0] period;
    logic       busy, done, lockup, timeout;

    logic       start2 = 1'b0;
    logic       in_valid2 = 1'b0;
    logic [7:0] state_in2 = '0;
    logic [7:0] ref_state2;
    logic [3:0] period2;
    logic       busy2, done2, lockup2, timeout2;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic       d;
        logic       l;
        logic       t;
        logic [7:0] per;
        logic [3:0] rf;
    } exp_t;

    exp_t sbq[$];
    logic [2:0] prev_flags = 3'b000;

    lfsr_period_checker #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .state_in(state_in),
        .ref_state(ref_state), .period(period), .busy(busy), .done(done),
        .lockup(lockup), .timeout(timeout)
    );

    lfsr_period_checker #(.WIDTH(8), .CNT_W(4)) dut_t (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .state_in(state_in2),
        .ref_state(ref_state2), .period(period2), .busy(busy2), .done(done2),
        .lockup(lockup2), .timeout(timeout2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] lfsr_nxt(input logic [3:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    task automatic push_exp(input int c, input logic d, input logic l, input logic t,
                            input logic [7:0] p, input logic [3:0] r);
        exp_t e;
        e.cyc = c; e.d = d; e.l = l; e.t = t; e.per = p; e.rf = r;
        sbq.push_back(e);
    endtask

    task automatic step(input logic v, input logic [3:0] s, input logic st);
        in_valid = v; state_in = s; start = st;
        in_valid2 = 1'b0; start2 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic step2(input logic v, input logic [7:0] s, input logic st);
        in_valid = 1'b0; start = 1'b0;
        in_valid2 = v; state_in2 = s; start2 = st;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        step(1'b0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        chk(tag, sbq.size(), 0);
    endtask

    // Result monitor: compare each rising result flag against the scoreboard head
    always @(negedge clk) begin
        if (rst && ({done, lockup, timeout} != 3'b000) && (prev_flags == 3'b000)) begin
            chk("sb_nonempty", (sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                chk("evt_cycle", cyc, sbq[0].cyc);
                chk("evt_done", done, sbq[0].d);
                chk("evt_lockup", lockup, sbq[0].l);
                chk("evt_timeout", timeout, sbq[0].t);
                chk("evt_period", period, sbq[0].per);
                chk("evt_ref", ref_state, sbq[0].rf);
                chk("evt_busy", busy, 0);
                chk("evt_onehot", $countones({done, lockup, timeout}), 1);
                sbq.pop_front();
            end
        end
        prev_flags <= {done, lockup, timeout};
    end

    initial begin
        logic [3:0]  lfsr;
        logic [15:0] gmask;
        int          t0;

        // Asynchronous reset, no clock edge yet
        #1 rst = 1'b0;
        #1;
        chk("rst_ref", ref_state, 0);
        chk("rst_period", period, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lockup", lockup, 0);
        chk("rst_timeout", timeout, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;

        // Plain full-period run from seed 1111
        step(1'b1, 4'h0, 1'b1);
        chk("start_busy", busy, 1);
        t0 = cyc;
        push_exp(t0 + 16, 1'b1, 1'b0, 1'b0, 8'd15, 4'hF);
        lfsr = 4'hF;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, lfsr, 1'b0);
            if (i == 0) chk("ref_after_capture", ref_state, 4'hF);
            if (i == 14) chk("done_not_early", done, 0);
            lfsr = lfsr_nxt(lfsr);
        end
        drain("sb_drain_plain");
        chk("done_hold", done, 1);
        chk("period_hold", period, 15);

        // Same stream with three invalid cycles inserted
        gmask = '0;
        while ($countones(gmask) < 3) gmask[$urandom_range(15, 2)] = 1'b1;
        step(1'b1, 4'h0, 1'b1);
        t0 = cyc;
        push_exp(t0 + 19, 1'b1, 1'b0, 1'b0, 8'd15, 4'hF);
        lfsr = 4'hF;
        for (int i = 0; i < 16; i++) begin
            if (gmask[i]) begin
                step(1'b0, 4'h0, 1'b0);
                chk("gap_busy", busy, 1);
            end
            step(1'b1, lfsr, 1'b0);
            lfsr = lfsr_nxt(lfsr);
        end
        drain("sb_drain_gaps");

        // Lockup at capture
        step(1'b1, 4'h5, 1'b1);
        t0 = cyc;
        push_exp(t0 + 1, 1'b0, 1'b1, 1'b0, 8'd0, 4'h0);
        step(1'b1, 4'h0, 1'b0);
        drain("sb_drain_lockup");
        chk("lockup_hold", lockup, 1);

        // Start while busy is ignored; start in DONE restarts
        step(1'b1, 4'h0, 1'b1);
        t0 = cyc;
        push_exp(t0 + 16, 1'b1, 1'b0, 1'b0, 8'd15, 4'hF);
        lfsr = 4'hF;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, lfsr, (i == 5));
            lfsr = lfsr_nxt(lfsr);
        end
        step(1'b1, 4'h0, 1'b1);
        chk("restart_done_clr", done, 0);
        chk("restart_busy", busy, 1);
        chk("restart_period_clr", period, 0);
        t0 = cyc;
        push_exp(t0 + 16, 1'b1, 1'b0, 1'b0, 8'd15, 4'hF);
        lfsr = 4'hF;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, lfsr, 1'b0);
            lfsr = lfsr_nxt(lfsr);
        end
        drain("sb_drain_restart");

        // Small counter: timeout after 15 non-matching samples
        step2(1'b1, 8'h00, 1'b1);
        step2(1'b1, 8'h80, 1'b0);
        chk("t_ref", ref_state2, 8'h80);
        for (int k = 1; k <= 15; k++) begin
            step2(1'b1, 8'(k), 1'b0);
            if (k == 14) begin
                chk("t_no_early_timeout", timeout2, 0);
                chk("t_busy_before", busy2, 1);
            end
        end
        chk("t_timeout", timeout2, 1);
        chk("t_done", done2, 0);
        chk("t_lockup", lockup2, 0);
        chk("t_busy", busy2, 0);

        // Small counter: match on the saturating sample
        step2(1'b1, 8'h00, 1'b1);
        chk("t_restart_clr", timeout2, 0);
        step2(1'b1, 8'h80, 1'b0);
        for (int k = 1; k <= 14; k++) step2(1'b1, 8'(k), 1'b0);
        step2(1'b1, 8'h80, 1'b0);
        chk("sat_done", done2, 1);
        chk("sat_period", period2, 15);
        chk("sat_timeout", timeout2, 0);
        step2(1'b0, 8'h00, 1'b0);
        chk("sat_hold", done2, 1);

        // Reset in the middle of a measurement
        step(1'b1, 4'h0, 1'b1);
        lfsr = 4'hF;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, lfsr, 1'b0);
            lfsr = lfsr_nxt(lfsr);
        end
        chk("mid_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_ref", ref_state, 0);
        chk("arst_busy", busy, 0);
        chk("arst_period", period, 0);
        chk("arst_flags", {done, lockup, timeout}, 0);
        step(1'b0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        rst = 1'b1;
        step(1'b1, 4'h3, 1'b0);
        step(1'b1, 4'h6, 1'b0);
        chk("post_rst_idle", busy, 0);
        step(1'b1, 4'h0, 1'b1);
        chk("post_rst_start", busy, 1);
        t0 = cyc;
        push_exp(t0 + 16, 1'b1, 1'b0, 1'b0, 8'd15, 4'hF);
        lfsr = 4'hF;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, lfsr, 1'b0);
            lfsr = lfsr_nxt(lfsr);
        end
        drain("sb_drain_post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
